addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a single shared N-bit adder/subtractor.
// Optional feature: define ADDSUB_ARB_OVF_EN to add the registered two's-complement overflow output rsp_ovf.
module addsub_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_m,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_m,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic         rsp_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t       state;
    state_t       state_next;
    logic         ptr;
    logic         grant0;
    logic         grant1;
    logic         op_id;
    logic         op_m;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] b_eff;
    logic [N:0]   add_res;

    // Shared adder/subtractor: subtract is a + ~b + 1, operands come only from the capture registers.
    assign b_eff   = op_m ? ~op_b : op_b;
    assign add_res = {1'b0, op_a} + {1'b0, b_eff} + (N+1)'(op_m);

`ifdef ADDSUB_ARB_OVF_EN
    logic add_ovf;
    assign add_ovf = (op_a[N-1] == b_eff[N-1]) && (add_res[N-1] != op_a[N-1]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are only possible in IDLE; ptr breaks ties and is held low while reset is asserted.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    grant0 = req0_valid && (!req1_valid || !ptr);
                    grant1 = req1_valid && (!req0_valid || ptr);
                end
                if (grant0 || grant1) begin
                    state_next = CALC;
                end
            end
            CALC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            op_id     <= 1'b0;
            op_m      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            if (grant0 || grant1) begin
                op_id <= grant1;
                op_a  <= grant1 ? req1_a : req0_a;
                op_b  <= grant1 ? req1_b : req0_b;
                op_m  <= grant1 ? req1_m : req0_m;
                ptr   <= grant0;
            end
            if (state == CALC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_sum   <= add_res[N-1:0];
                rsp_cout  <= add_res[N];
`ifdef ADDSUB_ARB_OVF_EN
                rsp_ovf   <= add_ovf;
`endif
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
